// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multicycle RV32I control unit:
// FSM state encoding, opcode values, ALU function codes and ALUSrcB selectors.
package control_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC     = 4'd2,
    ALUWB    = 4'd3,
    MEMADDR  = 4'd4,
    MEMREAD  = 4'd5,
    LWB      = 4'd6,
    MEMWRITE = 4'd7,
    BEQ      = 4'd8,
    PCINC    = 4'd9,
    HALT     = 4'd10
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam int ALU_W = 4;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'd4;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control FSM and the datapath.
interface multicycle_control_if #(
  parameter int ALUCTRL_W = 4,
  parameter int CNT_W     = 32
) ();

  logic                 iRun;
  logic [31:0]          iInst;
  logic                 iZero;
  logic                 oRegWrite;
  logic                 oALUSrcA;
  logic                 oMemRead;
  logic                 oMemWrite;
  logic                 oMemtoReg;
  logic                 oIoD;
  logic                 oIRWrite;
  logic                 oPCWrite;
  logic                 oPCWriteCond;
  logic                 oPCSource;
  logic                 oWritePCBack;
  logic [1:0]           oALUSrcB;
  logic [ALUCTRL_W-1:0] oALUOp;
  logic [3:0]           oState;
  logic                 oIllegal;
  logic [CNT_W-1:0]     oCycles;
  logic [CNT_W-1:0]     oInstret;

  modport slave (
    input  iRun, iInst, iZero,
    output oRegWrite, oALUSrcA, oMemRead, oMemWrite, oMemtoReg, oIoD,
           oIRWrite, oPCWrite, oPCWriteCond, oPCSource, oWritePCBack,
           oALUSrcB, oALUOp, oState, oIllegal, oCycles, oInstret
  );

  modport master (
    output iRun, iInst, iZero,
    input  oRegWrite, oALUSrcA, oMemRead, oMemWrite, oMemtoReg, oIoD,
           oIRWrite, oPCWrite, oPCWriteCond, oPCSource, oWritePCBack,
           oALUSrcB, oALUOp, oState, oIllegal, oCycles, oInstret
  );

endinterface

// File: rtl/multicycle_control_alu_decode.sv
// Maps opcode/funct3/funct7 of an ALU-class instruction to an ALU function
// code and reports whether the encoding is one this core implements.
module alu_decode
  import control_pkg::*;
(
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  output logic [ALU_W-1:0] alu_op,
  output logic             legal
);

  logic is_r;
  logic f7_ok;

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b0;
    is_r   = (opcode == OP_R);
    // I-type carries immediate bits in funct7, so only R-type constrains it
    f7_ok  = !is_r || (funct7 == F7_BASE) || (funct7 == F7_ALT);
    if (is_r || (opcode == OP_I)) begin
      legal = f7_ok;
      case (funct3)
        F3_ADD:  alu_op = (is_r && (funct7 == F7_ALT)) ? ALU_SUB : ALU_ADD;
        F3_SLT:  alu_op = ALU_SLT;
        F3_OR:   alu_op = ALU_OR;
        F3_AND:  alu_op = ALU_AND;
        default: legal  = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the multicycle RV32I datapath (R/I ALU, lw, sw, beq),
// with cycle/instret counters and a sticky illegal-instruction flag.
module multicycle_control
  import control_pkg::*;
#(
  parameter int ALUCTRL_W = 4,
  parameter int CNT_W     = 32
) (
  input logic                  clockCPU,
  input logic                  reset,
  multicycle_control_if.slave  bus
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cycles;
  logic [CNT_W-1:0] instret;
  logic             illegal;
  logic             retire;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [ALU_W-1:0] dec_alu_op;
  logic             dec_legal;
  logic             unused_inst_bits;

  logic             reg_write, alu_src_a, mem_read, mem_write, mem_to_reg, io_d;
  logic             ir_write, pc_write, pc_write_cond, pc_source, write_pc_back;
  logic             pc_inc;
  logic [1:0]       alu_src_b;
  logic [ALU_W-1:0] alu_sel;

  assign opcode           = bus.iInst[6:0];
  assign funct3           = bus.iInst[14:12];
  assign funct7           = bus.iInst[31:25];
  assign unused_inst_bits = ^{bus.iInst[24:15], bus.iInst[11:7]};

  alu_decode u_alu_decode (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .alu_op (dec_alu_op),
    .legal  (dec_legal)
  );

  // A transition into FETCH from any other state completes an instruction
  assign retire = (state_next == FETCH) && (state != FETCH);

  always_ff @(posedge clockCPU) begin
    if (!reset) begin
      state   <= FETCH;
      cycles  <= '0;
      instret <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (state != HALT) cycles <= cycles + 1'b1;
      if (retire) instret <= instret + 1'b1;
      if (state_next == HALT) illegal <= 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    io_d          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    write_pc_back = 1'b0;
    pc_inc        = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_sel       = ALU_ADD;

    case (state)
      FETCH: begin
        if (bus.iRun) begin
          mem_read   = 1'b1;
          ir_write   = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        alu_src_b     = SRCB_IMM;
        write_pc_back = 1'b1;
        case (opcode)
          OP_R, OP_I:        state_next = dec_legal ? EXEC : HALT;
          OP_LOAD, OP_STORE: state_next = MEMADDR;
          OP_BRANCH:         state_next = (funct3 == F3_BEQ) ? BEQ : HALT;
          default:           state_next = HALT;
        endcase
      end
      EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = (opcode == OP_R) ? SRCB_REG : SRCB_IMM;
        alu_sel    = dec_alu_op;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        pc_inc     = 1'b1;
        state_next = FETCH;
      end
      MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (funct3 != F3_WORD)      state_next = HALT;
        else if (opcode == OP_LOAD) state_next = MEMREAD;
        else                        state_next = MEMWRITE;
      end
      MEMREAD: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        io_d       = 1'b1;
        mem_read   = 1'b1;
        state_next = LWB;
      end
      LWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        pc_inc     = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        io_d       = 1'b1;
        mem_write  = 1'b1;
        pc_inc     = 1'b1;
        state_next = FETCH;
      end
      BEQ: begin
        alu_src_a     = 1'b1;
        alu_sel       = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        state_next    = bus.iZero ? FETCH : PCINC;
      end
      PCINC: begin
        pc_inc     = 1'b1;
        state_next = FETCH;
      end
      HALT:    state_next = HALT;
      default: state_next = HALT;
    endcase

    // Sequential PC+4 update shared by every writeback-style state
    if (pc_inc) begin
      alu_src_a = 1'b0;
      alu_src_b = SRCB_FOUR;
      alu_sel   = ALU_ADD;
      pc_source = 1'b0;
      pc_write  = 1'b1;
    end
  end

  assign bus.oRegWrite    = reg_write     & reset;
  assign bus.oALUSrcA     = alu_src_a     & reset;
  assign bus.oMemRead     = mem_read      & reset;
  assign bus.oMemWrite    = mem_write     & reset;
  assign bus.oMemtoReg    = mem_to_reg    & reset;
  assign bus.oIoD         = io_d          & reset;
  assign bus.oIRWrite     = ir_write      & reset;
  assign bus.oPCWrite     = pc_write      & reset;
  assign bus.oPCWriteCond = pc_write_cond & reset;
  assign bus.oPCSource    = pc_source     & reset;
  assign bus.oWritePCBack = write_pc_back & reset;
  assign bus.oALUSrcB     = alu_src_b;
  assign bus.oALUOp       = ALUCTRL_W'(alu_sel);
  assign bus.oState       = state;
  assign bus.oIllegal     = illegal;
  assign bus.oCycles      = cycles;
  assign bus.oInstret     = instret;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM that sequences the multicycle RISC-V datapath for RV32I subset R-ALU, I-ALU, lw, sw and beq.
- Decodes iInst (IR) and drives every datapath control strobe.
- Also keeps cycle and retired-instruction counters and flags illegal opcodes.
- Sits beside Datapath in the CPU top level, on clockCPU.

Parameters:
ALUCTRL_W, 4, width of oALUOp; the Datapath/ULA control input is this width.
CNT_W, 32, width of the cycle and instret counters.

Ports:
clockCPU  in  1  CPU clock; all state changes on its rising edge.
reset  in  1  synchronous, active-low reset.
iRun  in  1  run enable, sampled only in FETCH.
iInst  in  32  current IR contents.
iZero  in  1  ALU zero flag (combinational, current cycle).
oRegWrite, oALUSrcA, oMemRead, oMemWrite, oMemtoReg, oIoD, oIRWrite, oPCWrite, oPCWriteCond, oPCSource, oWritePCBack  out  1 each  datapath strobes.
oALUSrcB  out  2  00=B, 01=4, 10=imm.
oALUOp  out  ALUCTRL_W  ALU function code (package constants).
oState  out  4  current state encoding, for debug.
oIllegal  out  1  sticky; set on an undecodable instruction.
oCycles  out  CNT_W  cycles since reset, excluding HALT.
oInstret  out  CNT_W  instructions retired.

Behaviour:
- Reset: while reset==0 at a clockCPU edge, the block loads state=FETCH, counters=0 and oIllegal=0. While reset==0, all write strobes are forced to 0.
- Outputs are combinational from state and iInst. Every strobe not listed for a state is 0. oALUOp defaults to ADD.
- FETCH:
  - iRun=1: IoD=0, MemRead=1, IRWrite=1. Next state DECODE.
  - iRun=0: all strobes 0. Stay in FETCH. oCycles still counts.
- DECODE: ALUSrcA=0, ALUSrcB=10, ADD, WritePCBack=1, giving ALUOut = PC+imm (branch target). Next state by opcode:
  - 0110011 or 0010011 -> EXEC.
  - 0000011 or 0100011 -> MEMADDR.
  - 1100011 -> BEQ.
  - any other opcode -> HALT.
- EXEC: ALUSrcA=1. ALUSrcB=00 for R-type, 10 for I-type. oALUOp from funct3/funct7:
  - 000 -> ADD; with R-type funct7=0100000 -> SUB.
  - 010 -> SLT. 110 -> OR. 111 -> AND.
  - Any other funct3, or R-type funct7 not in {0000000, 0100000}, -> HALT (checked in DECODE).
  - Next state ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0 (writes the registered ALUOut). Same cycle: ALUSrcA=0, ALUSrcB=01, ADD, PCSource=0, PCWrite=1 (PC+4). Next state FETCH, retire.
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ADD. funct3 must be 010, else HALT. Next state MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: IoD=1, MemRead=1, ALU controls as in MEMADDR (ALUOut holds the address). Next state LWB.
- LWB: RegWrite=1, MemtoReg=1, plus the PC+4 controls of ALUWB. Next state FETCH, retire.
- MEMWRITE: IoD=1, MemWrite=1, plus the PC+4 controls. Next state FETCH, retire.
- BEQ: ALUSrcA=1, ALUSrcB=00, SUB, PCWriteCond=1, PCSource=1. funct3 must be 000, else HALT (checked in DECODE).
  - iZero=1 -> FETCH, retire.
  - iZero=0 -> PCINC.
- PCINC: PC+4 controls. Next state FETCH, retire.
- HALT: all strobes 0, oIllegal=1. Stays in HALT until reset. Counters frozen.
- Latency in cycles: R/I = 4, lw = 5, sw = 4, beq taken = 3, beq not taken = 4.
- oInstret increments on each retiring transition into FETCH. Both counters wrap modulo 2^CNT_W.
- Reset in any state, including mid-lw or mid-sw, aborts the instruction: no retire, next state FETCH.

Decomposition:
- Package control_pkg holds:
  - state enum: FETCH, DECODE, EXEC, ALUWB, MEMADDR, MEMREAD, LWB, MEMWRITE, BEQ, PCINC, HALT.
  - opcode constants.
  - ALU codes ADD=0, SUB=1, AND=2, OR=3, SLT=4.
  - ALUSrcB selector constants.
- One sub-module, alu_decode: combinational mapping of opcode/funct3/funct7 to oALUOp plus a legal flag.

Test Plan:
1. Hold reset=0 for 3 cycles, then release with iRun=1 -> state FETCH on the first cycle; all strobes 0 during reset; oCycles=0, oInstret=0.
2. iInst=add x3,x1,x2 (0x002081B3) -> states FETCH, DECODE, EXEC, ALUWB. oALUOp=ADD in EXEC. RegWrite=1 and PCWrite=1 in ALUWB only. oInstret 0 -> 1 after 4 cycles.
3. iInst=lw x5,8(x0) (0x00802283) -> 5 cycles. MemRead=1, IoD=1 in MEMREAD. MemtoReg=1, RegWrite=1 in LWB. sw x5,8(x0) (0x00502423) -> MemWrite=1 in cycle 4 only.
4. beq (0x00208463): iZero=1 -> 3 cycles, PCWriteCond=1, PCSource=1 in BEQ. iZero=0 -> next state PCINC, PCWrite=1, total 4 cycles.
5. iInst=0xFFFFFFFF -> HALT after DECODE. oIllegal=1; strobes and counters frozen for 10 cycles; reset=0 returns to FETCH with oIllegal=0.
6. Reset asserted in MEMREAD, then iRun=0 in FETCH -> FETCH after reset, no retire. FETCH holds with IRWrite=0; oCycles keeps counting.
